// File: rtl/synth_spi_pkg.sv
// synth_spi_pkg: shared constants, FSM state type and frame byte selection
// for the synthyboy SPI command master.
package synth_spi_pkg;

    // Synth register addresses and the trailing kick byte.
    localparam logic [7:0] REG_WAVE  = 8'h01;
    localparam logic [7:0] REG_FREQ  = 8'h02;
    localparam logic [7:0] REG_AMP   = 8'h04;
    localparam logic [7:0] KICK_BYTE = 8'h00;

    // 52 us SCLK half-period and 416 us inter-frame gap at 50 MHz.
    localparam int DEF_CLK_DIV    = 2600;
    localparam int DEF_GAP_CYCLES = 20800;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } state_t;

    // Byte for frame idx: address first, then data MSB-first. Any index past
    // the data bytes can only be the kick frame, since the sequencer stops at
    // 1 + len + kick frames.
    function automatic logic [7:0] frame_byte(input logic [7:0]  addr,
                                              input logic [23:0] data,
                                              input logic [1:0]  len,
                                              input logic [2:0]  idx);
        logic [7:0] b;
        b = KICK_BYTE;
        if (idx == 3'd0) begin
            b = addr;
        end else if (idx <= {1'b0, len}) begin
            case (idx)
                3'd1:    b = data[23:16];
                3'd2:    b = data[15:8];
                3'd3:    b = data[7:0];
                default: b = KICK_BYTE;
            endcase
        end
        return b;
    endfunction

endpackage

// File: rtl/synth_spi_cmd_master_shifter.sv
// spi_byte_shifter: one mode-0, MSB-first SPI byte frame.
//   clk, rst_n    system clock, async active-low reset
//   load          start a frame with tx_byte (SS falls next cycle)
//   miso          serial input, sampled on SCLK rising edges
//   sclk/mosi/ss_n registered SPI pins
//   rx_byte/rx_valid byte received, updated as SS rises
//   sclk_last     strobe: the 8th falling edge happens on this clock edge
//   frame_end     strobe: SS rises on this clock edge
module spi_byte_shifter
    import synth_spi_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       sclk,
    output logic       mosi,
    output logic       ss_n,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       sclk_last,
    output logic       frame_end
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic [4:0]       half_cnt;   // half-periods 0..15 toggle SCLK, 16 is the SS hold
    logic [7:0]       tx_sr;
    logic [7:0]       rx_sr;
    logic             active;
    logic             div_wrap;

    assign div_wrap  = active && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign sclk_last = div_wrap && (half_cnt == 5'd15);
    assign frame_end = div_wrap && (half_cnt == 5'd16);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            half_cnt <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            active   <= 1'b0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            ss_n     <= 1'b1;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (load) begin
                active   <= 1'b1;
                ss_n     <= 1'b0;
                tx_sr    <= tx_byte;
                mosi     <= tx_byte[7];
                div_cnt  <= '0;
                half_cnt <= '0;
                sclk     <= 1'b0;
            end else if (active) begin
                if (div_wrap) begin
                    div_cnt  <= '0;
                    half_cnt <= half_cnt + 5'd1;
                    if (half_cnt == 5'd16) begin
                        active   <= 1'b0;
                        ss_n     <= 1'b1;
                        rx_byte  <= rx_sr;
                        rx_valid <= 1'b1;
                    end else if (!half_cnt[0]) begin
                        sclk  <= 1'b1;
                        rx_sr <= {rx_sr[6:0], miso};
                    end else begin
                        sclk <= 1'b0;
                        // Last falling edge keeps the final bit on MOSI.
                        if (half_cnt != 5'd15) begin
                            tx_sr <= {tx_sr[6:0], 1'b0};
                            mosi  <= tx_sr[6];
                        end
                    end
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/synth_spi_cmd_master.sv
// synth_spi_cmd_master: turns one register-write command into byte frames
// (addr, 0-3 data bytes, optional 0x00 kick), each its own SS-low frame,
// followed by GAP_CYCLES of SS high.
//   i_clk50mhz, i_rst_n          clock, async active-low reset
//   i_cmd_valid/o_cmd_ready      command handshake (ready only when idle)
//   i_cmd_addr/data/len/kick     command fields, latched on accept
//   o_spi_clk/mosi/ss, i_spi_miso SPI pins
//   o_rx_byte/o_rx_valid         byte captured per frame
//   o_busy                       inverse of o_cmd_ready
module synth_spi_cmd_master
    import synth_spi_pkg::*;
#(
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic        i_clk50mhz,
    input  logic        i_rst_n,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic [7:0]  i_cmd_addr,
    input  logic [23:0] i_cmd_data,
    input  logic [1:0]  i_cmd_len,
    input  logic        i_cmd_kick,
    output logic        o_spi_clk,
    output logic        o_spi_mosi,
    output logic        o_spi_ss,
    input  logic        i_spi_miso,
    output logic [7:0]  o_rx_byte,
    output logic        o_rx_valid,
    output logic        o_busy
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_t           state, state_nxt;
    logic [7:0]       addr_q;
    logic [23:0]      data_q;
    logic [1:0]       len_q;
    logic             kick_q;
    logic [2:0]       idx_q;      // frames already loaded
    logic [2:0]       n_frames;
    logic [GAP_W-1:0] gap_cnt;
    logic             accept, load, more, gap_last;
    logic             sclk_last, frame_end;

    assign accept   = i_cmd_valid && o_cmd_ready;
    assign load     = (state == ST_LOAD);
    assign n_frames = 3'd1 + {1'b0, len_q} + {2'b0, kick_q};
    assign more     = (idx_q < n_frames);

    // The LOAD cycle itself is the last SS-high cycle before the next frame,
    // so the gap state exits one cycle early when another frame follows.
    assign gap_last = more ? (gap_cnt == GAP_W'(GAP_CYCLES - 2))
                           : (gap_cnt == GAP_W'(GAP_CYCLES - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = ST_SHIFT;
            ST_SHIFT: if (sclk_last) state_nxt = ST_HOLD;
            ST_HOLD:  if (frame_end) state_nxt = (more && GAP_CYCLES == 1) ? ST_LOAD : ST_GAP;
            ST_GAP:   if (gap_last) state_nxt = more ? ST_LOAD : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk50mhz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            len_q       <= '0;
            kick_q      <= 1'b0;
            idx_q       <= '0;
            gap_cnt     <= '0;
            o_cmd_ready <= 1'b1;
            o_busy      <= 1'b0;
        end else begin
            state       <= state_nxt;
            o_cmd_ready <= (state_nxt == ST_IDLE);
            o_busy      <= (state_nxt != ST_IDLE);
            if (accept) begin
                addr_q <= i_cmd_addr;
                data_q <= i_cmd_data;
                len_q  <= i_cmd_len;
                kick_q <= i_cmd_kick;
                idx_q  <= '0;
            end else if (load) begin
                idx_q <= idx_q + 3'd1;
            end
            gap_cnt <= (state == ST_GAP) ? gap_cnt + 1'b1 : '0;
        end
    end

    spi_byte_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk       (i_clk50mhz),
        .rst_n     (i_rst_n),
        .load      (load),
        .tx_byte   (frame_byte(addr_q, data_q, len_q, idx_q)),
        .miso      (i_spi_miso),
        .sclk      (o_spi_clk),
        .mosi      (o_spi_mosi),
        .ss_n      (o_spi_ss),
        .rx_byte   (o_rx_byte),
        .rx_valid  (o_rx_valid),
        .sclk_last (sclk_last),
        .frame_end (frame_end)
    );

endmodule

// File: tb/tb_synth_spi_cmd_master.sv
module tb_synth_spi_cmd_master;
    import synth_spi_pkg::*;

    localparam int CD  = 2;
    localparam int GAP = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [7:0]  cmd_addr = '0;
    logic [23:0] cmd_data = '0;
    logic [1:0]  cmd_len = '0;
    logic        cmd_kick = 1'b0;
    logic        loopback = 1'b0;
    logic        miso;
    logic        cmd_ready, spi_clk, spi_mosi, spi_ss, rx_valid, busy;
    logic [7:0]  rx_byte;

    assign miso = loopback ? spi_mosi : 1'b0;

    always #5 clk = ~clk;

    synth_spi_cmd_master #(.CLK_DIV(CD), .GAP_CYCLES(GAP)) dut (
        .i_clk50mhz (clk),
        .i_rst_n    (rst_n),
        .i_cmd_valid(cmd_valid),
        .o_cmd_ready(cmd_ready),
        .i_cmd_addr (cmd_addr),
        .i_cmd_data (cmd_data),
        .i_cmd_len  (cmd_len),
        .i_cmd_kick (cmd_kick),
        .o_spi_clk  (spi_clk),
        .o_spi_mosi (spi_mosi),
        .o_spi_ss   (spi_ss),
        .i_spi_miso (miso),
        .o_rx_byte  (rx_byte),
        .o_rx_valid (rx_valid),
        .o_busy     (busy)
    );

    int checks = 0;
    int failures = 0;

    // Slave model: decodes frames on SCLK rising edges, sampled on negedge.
    logic [7:0] byteq[$];
    logic [7:0] rxq[$];
    int lowq[$], pulseq[$], gapq[$];
    int cyc = 0, low_cnt = 0, pulses = 0, high_cnt = 0;
    int rise_cyc = 0, rdy_cyc = 0, sclk_bad = 0, rxv_misalign = 0;
    logic [7:0] sh = '0;
    logic prev_ss = 1'b1, prev_sclk = 1'b0, prev_rdy = 1'b1, seen_end = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            low_cnt = 0; pulses = 0; sh = '0;
        end else begin
            if (prev_ss && !spi_ss) begin
                if (seen_end) gapq.push_back(high_cnt);
                low_cnt = 0; pulses = 0; sh = '0;
            end
            if (!spi_ss) begin
                low_cnt++;
                if (!prev_sclk && spi_clk) begin
                    sh = {sh[6:0], spi_mosi};
                    pulses++;
                end
            end
            if (!prev_ss && spi_ss) begin
                byteq.push_back(sh); lowq.push_back(low_cnt); pulseq.push_back(pulses);
                rise_cyc = cyc; seen_end = 1'b1; high_cnt = 0;
            end
            if (spi_ss) high_cnt++;
            if (spi_ss && spi_clk) sclk_bad++;
            if (rx_valid) begin
                rxq.push_back(rx_byte);
                if (!(!prev_ss && spi_ss)) rxv_misalign++;
            end
            if (cmd_ready && !prev_rdy) rdy_cyc = cyc;
        end
        prev_ss = spi_ss; prev_sclk = spi_clk; prev_rdy = cmd_ready;
    end

    task automatic clear_mon();
        byteq.delete(); rxq.delete(); lowq.delete(); pulseq.delete(); gapq.delete();
        seen_end = 1'b0; sclk_bad = 0; rxv_misalign = 0;
    endtask

    task automatic drive_cmd(input logic [7:0] a, input logic [23:0] d,
                             input logic [1:0] l, input logic k);
        cmd_addr = a; cmd_data = d; cmd_len = l; cmd_kick = k; cmd_valid = 1'b1;
    endtask

    // Waits for the accepting edge; leaves the bench on the negedge after it.
    task automatic wait_accept();
        int n = 0;
        while (!cmd_ready && n < 3000) begin @(negedge clk); n++; end
        if (n >= 3000) begin
            checks++; failures++;
            $display("FAIL accept_timeout: ready=%0b required=1", cmd_ready);
        end
        @(negedge clk);
    endtask

    task automatic send_cmd(input logic [7:0] a, input logic [23:0] d,
                            input logic [1:0] l, input logic k);
        @(negedge clk);
        drive_cmd(a, d, l, k);
        wait_accept();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!cmd_ready && n < 3000) begin @(negedge clk); n++; end
        if (n >= 3000) begin
            checks++; failures++;
            $display("FAIL idle_timeout: ready=%0b required=1", cmd_ready);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({spi_ss, spi_clk, spi_mosi, rx_valid, cmd_ready, busy} !== 6'b100010) begin
            failures++;
            $display("FAIL reset_pins: ss/sclk/mosi/rxv/rdy/busy=%b required=100010",
                     {spi_ss, spi_clk, spi_mosi, rx_valid, cmd_ready, busy});
        end
        checks++;
        if (rx_byte !== 8'h00) begin
            failures++; $display("FAIL reset_rx_byte: got=%h required=00", rx_byte);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || spi_ss !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_idle: ready=%b ss=%b required=1,1", cmd_ready, spi_ss);
        end
    endtask

    task automatic test_wave();
        logic [7:0] exp [3] = '{8'h01, 8'h01, 8'h00};
        clear_mon();
        send_cmd(REG_WAVE, 24'h010000, 2'd1, 1'b1);
        wait_idle();
        checks++;
        if (byteq.size() != 3) begin
            failures++; $display("FAIL wave_frames: got=%0d required=3", byteq.size());
        end
        for (int i = 0; i < 3 && i < byteq.size(); i++) begin
            checks++;
            if (byteq[i] !== exp[i]) begin
                failures++; $display("FAIL wave_byte%0d: got=%h required=%h", i, byteq[i], exp[i]);
            end
            checks++;
            if (lowq[i] != 2 * 17 * CD / 2) begin
                failures++; $display("FAIL wave_ss_low%0d: got=%0d required=34", i, lowq[i]);
            end
            checks++;
            if (pulseq[i] != 8) begin
                failures++; $display("FAIL wave_pulses%0d: got=%0d required=8", i, pulseq[i]);
            end
        end
        checks++;
        if (gapq.size() != 2 || gapq[0] != GAP || gapq[1] != GAP) begin
            failures++;
            $display("FAIL wave_gaps: count=%0d first=%0d required=2 gaps of %0d",
                     gapq.size(), (gapq.size() > 0) ? gapq[0] : -1, GAP);
        end
        checks++;
        if (rdy_cyc - rise_cyc != GAP) begin
            failures++; $display("FAIL wave_ready_delay: got=%0d required=%0d", rdy_cyc - rise_cyc, GAP);
        end
        checks++;
        if (sclk_bad != 0) begin
            failures++; $display("FAIL sclk_while_ss_high: got=%0d required=0", sclk_bad);
        end
    endtask

    task automatic test_freq();
        logic [7:0] exp [5] = '{8'h02, 8'hFF, 8'hFF, 8'h03, 8'h00};
        clear_mon();
        send_cmd(REG_FREQ, 24'hFFFF03, 2'd3, 1'b1);
        wait_idle();
        checks++;
        if (byteq.size() != 5) begin
            failures++; $display("FAIL freq_frames: got=%0d required=5", byteq.size());
        end
        for (int i = 0; i < 5 && i < byteq.size(); i++) begin
            checks++;
            if (byteq[i] !== exp[i]) begin
                failures++; $display("FAIL freq_byte%0d: got=%h required=%h", i, byteq[i], exp[i]);
            end
        end
        for (int i = 0; i < gapq.size(); i++) begin
            checks++;
            if (gapq[i] != GAP) begin
                failures++; $display("FAIL freq_gap%0d: got=%0d required=%0d", i, gapq[i], GAP);
            end
        end
    endtask

    task automatic test_loopback();
        logic [7:0] exp [3] = '{8'h04, 8'hFF, 8'h7F};
        clear_mon();
        loopback = 1'b1;
        send_cmd(REG_AMP, 24'hFF7F00, 2'd2, 1'b0);
        wait_idle();
        loopback = 1'b0;
        checks++;
        if (rxq.size() != 3) begin
            failures++; $display("FAIL loop_rx_pulses: got=%0d required=3", rxq.size());
        end
        for (int i = 0; i < 3 && i < rxq.size(); i++) begin
            checks++;
            if (rxq[i] !== exp[i]) begin
                failures++; $display("FAIL loop_rx%0d: got=%h required=%h", i, rxq[i], exp[i]);
            end
        end
        checks++;
        if (rxv_misalign != 0) begin
            failures++; $display("FAIL rx_valid_vs_ss_rise: misaligned=%0d required=0", rxv_misalign);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [5] = '{8'h01, 8'h01, 8'h00, 8'h01, 8'h03};
        clear_mon();
        @(negedge clk);
        drive_cmd(REG_WAVE, 24'h010000, 2'd1, 1'b1);
        wait_accept();
        drive_cmd(REG_WAVE, 24'h030000, 2'd1, 1'b0);
        wait_accept();
        cmd_valid = 1'b0;
        wait_idle();
        checks++;
        if (byteq.size() != 5) begin
            failures++; $display("FAIL b2b_frames: got=%0d required=5", byteq.size());
        end
        for (int i = 0; i < 5 && i < byteq.size(); i++) begin
            checks++;
            if (byteq[i] !== exp[i]) begin
                failures++; $display("FAIL b2b_byte%0d: got=%h required=%h", i, byteq[i], exp[i]);
            end
        end
        // Second command starts only after the full gap, plus accept and load.
        checks++;
        if (gapq.size() != 4 || gapq[0] != GAP || gapq[1] != GAP || gapq[2] != GAP + 2 || gapq[3] != GAP) begin
            failures++;
            $display("FAIL b2b_gaps: count=%0d third=%0d required=4 gaps, third=%0d",
                     gapq.size(), (gapq.size() > 2) ? gapq[2] : -1, GAP + 2);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        clear_mon();
        send_cmd(8'hFF, 24'h000000, 2'd0, 1'b0);
        while (spi_ss && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin
            checks++; failures++; $display("FAIL mid_no_frame: ss=%b required=0", spi_ss);
        end
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({spi_ss, spi_clk, spi_mosi, rx_valid} !== 4'b1000) begin
            failures++;
            $display("FAIL mid_reset_pins: ss/sclk/mosi/rxv=%b required=1000",
                     {spi_ss, spi_clk, spi_mosi, rx_valid});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || rxq.size() != 0) begin
            failures++;
            $display("FAIL mid_after_release: ready=%b busy=%b rx_pulses=%0d required=1,0,0",
                     cmd_ready, busy, rxq.size());
        end
        clear_mon();
        send_cmd(REG_WAVE, 24'h000000, 2'd0, 1'b0);
        wait_idle();
        checks++;
        if (byteq.size() != 1 || byteq[0] !== 8'h01) begin
            failures++;
            $display("FAIL mid_fresh_cmd: frames=%0d first=%h required=1 frame 01",
                     byteq.size(), (byteq.size() > 0) ? byteq[0] : 8'hXX);
        end
    endtask

    task automatic test_addr_only();
        clear_mon();
        send_cmd(8'hA5, 24'h123456, 2'd0, 1'b0);
        wait_idle();
        checks++;
        if (byteq.size() != 1) begin
            failures++; $display("FAIL addr_only_frames: got=%0d required=1", byteq.size());
        end
        if (byteq.size() > 0) begin
            checks++;
            if (byteq[0] !== 8'hA5) begin
                failures++; $display("FAIL addr_only_bits: got=%b required=10100101", byteq[0]);
            end
            checks++;
            if (lowq[0] != 34 || pulseq[0] != 8) begin
                failures++;
                $display("FAIL addr_only_shape: low=%0d pulses=%0d required=34,8", lowq[0], pulseq[0]);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: sim time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_wave();
        test_freq();
        test_loopback();
        test_back_to_back();
        test_reset_mid();
        test_addr_only();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/synth_spi_cmd_master.md
Name: synth_spi_cmd_master

Overview:
- SPI initiator (controller side) for the synthyboy register interface. It turns one parallel register-write command into the byte-framed SPI sequence the synth slave expects.
- Frame sequence: address byte, then 0-3 data bytes, then an optional 0x00 "kick" byte.
- Each byte is its own SS-low frame. Timing is mode 0, MSB first.
- Sits between a control/sequencer source (front-panel decoder, MIDI parser) and the synth SPI pins.
- Also captures MISO per byte for readback.

Parameters:
- CLK_DIV, 2600, system clocks per SCLK half-period (52 us at 50 MHz); minimum 2.
- GAP_CYCLES, 20800, system clocks SS stays high after every frame (416 us); minimum 1.

Ports:
- i_clk50mhz  in  1  system clock, 50 MHz.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_cmd_valid  in  1  command request.
- o_cmd_ready  out  1  high only when idle; a command is accepted on a clock edge where i_cmd_valid && o_cmd_ready.
- i_cmd_addr  in  8  register address byte (0x01 wave, 0x02 freq, 0x04 amp).
- i_cmd_data  in  24  data bytes, sent from [23:16] downward.
- i_cmd_len  in  2  number of data bytes, 0-3.
- i_cmd_kick  in  1  append 0x00 kick frame after the data bytes.
- o_spi_clk  out  1  SCLK; idles low.
- o_spi_mosi  out  1  serial data, MSB first.
- o_spi_ss  out  1  slave select, active-low.
- i_spi_miso  in  1  serial data from the slave.
- o_rx_byte  out  8  byte captured during the last frame.
- o_rx_valid  out  1  one-cycle pulse when o_rx_byte updates.
- o_busy  out  1  equals !o_cmd_ready.

Behaviour:
- Reset (asynchronous, immediate, also mid-frame):
  - o_spi_ss=1, o_spi_clk=0, o_spi_mosi=0, o_rx_byte=0x00, o_rx_valid=0, o_cmd_ready=1.
  - All counters and the state machine return to IDLE.
- On accept, latch addr/data/len/kick. Byte queue: addr, data[23:16], data[15:8], data[7:0] (first len data bytes only), then 0x00 if kick. Queue length is 1-5 frames.
- State machine: IDLE -> LOAD -> SHIFT -> HOLD -> GAP -> (LOAD if bytes remain, else IDLE).
  - LOAD (1 cycle): select the next byte and load the shifter.
  - Frame start: SS falls on the first SHIFT cycle, which is the 2nd clock edge after accept (1 cycle in LOAD). MOSI presents bit7 in the same cycle.
  - Frame-relative cycle t=0 is the cycle SS falls.
  - SCLK rising edges at t = CLK_DIV*(2k+1), k=0..7. MISO is sampled into the rx shifter on each rising edge.
  - SCLK falling edges at t = CLK_DIV*(2k+2). MOSI advances to the next bit on falling edges 1-7. On the 8th falling edge MOSI is held and SCLK stays low.
  - HOLD: SS rises at t = 17*CLK_DIV, so SS low lasts 17*CLK_DIV cycles and each frame has exactly 8 SCLK pulses.
  - o_rx_valid pulses and o_rx_byte updates in the same cycle SS rises.
  - GAP: SS held high GAP_CYCLES cycles after every frame, including the last. o_cmd_ready rises in the cycle after the final gap completes.
- While busy, i_cmd_valid is ignored; nothing is queued and the command inputs are not sampled.
- i_cmd_len=0 with i_cmd_kick=0 sends the address frame alone.
- SCLK stays low whenever SS is high; no glitches on SS or SCLK.
- Dividers count 0..CLK_DIV-1 and 0..GAP_CYCLES-1, then wrap with no drift.
- All outputs are registered.

Decomposition:
- Package synth_spi_pkg holds:
  - Register address constants: REG_WAVE=8'h01, REG_FREQ=8'h02, REG_AMP=8'h04, KICK_BYTE=8'h00.
  - FSM state enum.
  - Default CLK_DIV and GAP_CYCLES.
- One natural sub-module, spi_byte_shifter: load, half-period divider, 8-bit TX/RX shift, done pulse.
- Frame sequencing and gap timing stay in the top level.

Test Plan:
- CLK_DIV=2, GAP_CYCLES=4 for all scenarios; a slave model decodes MOSI on SCLK rising edges.
1. Wave select: addr 0x01, len1, data 0x010000, kick=1 -> frames 0x01, 0x01, 0x00.
   - Each frame: SS low exactly 34 cycles with 8 SCLK pulses; SS high 4 cycles between frames.
   - o_cmd_ready returns 4 cycles after the last SS rise.
2. Freq write: addr 0x02, len3, data 0xFFFF03, kick=1 -> frames 0x02, 0xFF, 0xFF, 0x03, 0x00 in that order.
3. MISO loopback (i_spi_miso tied to o_spi_mosi), amp command addr 0x04, data 0xFF7F00, len2, kick=0 -> o_rx_valid pulses 3 times; o_rx_byte = 0x04, 0xFF, 0x7F.
4. Hold i_cmd_valid high with a second command (addr 0x01, len1, data 0x03) during command 1 -> second command is accepted only after command 1's final gap, and its frames follow without any overlap.
5. Assert i_rst_n=0 mid-frame at bit 4 -> SS=1, SCLK=0, MOSI=0 immediately, before the next clock edge; no o_rx_valid. After release, o_cmd_ready=1 and a fresh command 0x01/len0/kick0 sends the single frame 0x01.
6. len0, kick0, addr 0xA5 -> exactly one frame 0xA5; MOSI bit sequence 1,0,1,0,0,1,0,1 at the rising edges.
